// File: rtl/exp2_iter.sv
// Iterative base-2 antilog: floor(2^e * (1 + f/2^F)), one left shift per clock.
// Operand and result both use valid/ready handshakes; overflow saturates to all ones.
module exp2_iter #(
    parameter int N = 8,
    parameter int M = 3,
    parameter int F = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] exp_in,
    input  logic [F-1:0] frac_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         exact,
    output logic         ovf
);

    localparam int AW = N + F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [M-1:0]  cnt_q, cnt_d;
    logic [N-1:0]  result_q, result_d;
    logic          exact_q, exact_d;
    logic          ovf_q, ovf_d;

    logic [AW-1:0] acc_load;
    logic [AW-1:0] acc_shl;
    logic          exp_big;

    // Operand with its implicit leading one, in the low F+1 bits of the accumulator.
    always_comb begin
        acc_load        = '0;
        acc_load[F:0]   = {1'b1, frac_in};
    end

    assign acc_shl = acc_q << 1;
    assign exp_big = int'(exp_in) >= N;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        exact_d   = exact_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = acc_load;
                    cnt_d   = exp_in;
                    exact_d = (frac_in == '0);
                    if (exp_big) begin
                        result_d = '1;
                        ovf_d    = 1'b1;
                        exact_d  = 1'b0;
                        state_d  = DONE;
                    end else if (exp_in == '0) begin
                        result_d = acc_load[AW-1:F];
                        ovf_d    = 1'b0;
                        state_d  = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_shl;
                cnt_d = cnt_q - M'(1);
                // e < N guarantees the leading one stays inside the accumulator.
                if (cnt_q == M'(1)) begin
                    result_d = acc_shl[AW-1:F];
                    ovf_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exact_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exact_q  <= exact_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result = result_q;
    assign exact  = exact_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_exp2_iter.sv
// Directed bench for exp2_iter: an N=8 instance for the main function and an
// N=4 instance for the overflow path, with hand-computed expected values.
module tb_exp2_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance A: N=8, M=3, F=4
    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [2:0] a_exp = '0;
    logic [3:0] a_frac = '0;
    logic       a_out_valid;
    logic       a_out_ready = 1'b0;
    logic [7:0] a_result;
    logic       a_exact;
    logic       a_ovf;

    // Instance B: N=4, M=3, F=4
    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [2:0] b_exp = '0;
    logic [3:0] b_frac = '0;
    logic       b_out_valid;
    logic       b_out_ready = 1'b0;
    logic [3:0] b_result;
    logic       b_exact;
    logic       b_ovf;

    exp2_iter #(.N(8), .M(3), .F(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .exp_in    (a_exp),
        .frac_in   (a_frac),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .result    (a_result),
        .exact     (a_exact),
        .ovf       (a_ovf)
    );

    exp2_iter #(.N(4), .M(3), .F(4)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .exp_in    (b_exp),
        .frac_in   (b_frac),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .result    (b_result),
        .exact     (b_exact),
        .ovf       (b_ovf)
    );

    // Observation mux so one driver task can serve either instance.
    logic       sel_b = 1'b0;
    logic [7:0] o_result;
    logic       o_exact, o_ovf, o_out_valid, o_in_ready;

    assign o_result    = sel_b ? {4'b0000, b_result} : a_result;
    assign o_exact     = sel_b ? b_exact     : a_exact;
    assign o_ovf       = sel_b ? b_ovf       : a_ovf;
    assign o_out_valid = sel_b ? b_out_valid : a_out_valid;
    assign o_in_ready  = sel_b ? b_in_ready  : a_in_ready;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input int e, input int f);
        if (sel_b) begin
            b_in_valid = v;
            b_exp      = e[2:0];
            b_frac     = f[3:0];
        end else begin
            a_in_valid = v;
            a_exp      = e[2:0];
            a_frac     = f[3:0];
        end
    endtask

    task automatic set_out_ready(input logic r);
        if (sel_b) b_out_ready = r;
        else       a_out_ready = r;
    endtask

    // Count edges from the accepting edge (inclusive) until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!o_out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // One complete transaction with immediate output acceptance.
    task automatic run_op(input string tag, input int e, input int f,
                          input int exp_res, input int exp_exact, input int exp_ovf,
                          input int exp_lat);
        int lat;
        chk({tag, "_in_ready"}, o_in_ready, 1);
        drive_in(1'b1, e, f);
        tick();
        drive_in(1'b0, 0, 0);
        wait_done(lat);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, o_result, exp_res);
        chk({tag, "_exact"}, o_exact, exp_exact);
        chk({tag, "_ovf"}, o_ovf, exp_ovf);
        set_out_ready(1'b1);
        tick();
        set_out_ready(1'b0);
        chk({tag, "_idle_out_valid"}, o_out_valid, 0);
    endtask

    initial begin
        int lat;

        // Reset in idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sel_b = 1'b0;
        #1;
        chk("rst_in_ready", o_in_ready, 1);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_result", o_result, 0);
        chk("rst_exact", o_exact, 0);
        chk("rst_ovf", o_ovf, 0);

        // Exact powers and fractional values, N=8
        run_op("e6_f0",  6, 0,  64, 1, 0, 7);
        run_op("e0_f0",  0, 0,   1, 1, 0, 1);
        run_op("e5_f8",  5, 8,  48, 0, 0, 6);
        run_op("e2_f4",  2, 4,   5, 0, 0, 3);
        run_op("e0_f15", 0, 15,  1, 0, 0, 1);
        run_op("e7_f15", 7, 15, 248, 0, 0, 8);

        // Overflow and largest in-range exponent, N=4
        sel_b = 1'b1;
        #1;
        chk("b_rst_result", o_result, 0);
        run_op("b_e5_f3", 5, 3, 15, 0, 1, 1);
        run_op("b_e3_f8", 3, 8, 12, 0, 0, 4);
        run_op("b_e4_f0", 4, 0, 15, 0, 1, 1);
        sel_b = 1'b0;
        #1;

        // Back-pressure with a competing operand held on the input throughout
        drive_in(1'b1, 4, 0);
        tick();
        drive_in(1'b1, 1, 15);
        chk("bp_busy_in_ready", o_in_ready, 0);
        wait_done(lat);
        chk("bp_latency", lat, 5);
        chk("bp_result", o_result, 16);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_hold%0d_valid", i), o_out_valid, 1);
            chk($sformatf("bp_hold%0d_result", i), o_result, 16);
            chk($sformatf("bp_hold%0d_in_ready", i), o_in_ready, 0);
        end
        chk("bp_exact", o_exact, 1);
        drive_in(1'b0, 0, 0);
        set_out_ready(1'b1);
        tick();
        set_out_ready(1'b0);
        chk("bp_release_in_ready", o_in_ready, 1);
        chk("bp_release_out_valid", o_out_valid, 0);
        chk("bp_kept_result", o_result, 16);
        tick();
        chk("bp_no_queue_out_valid", o_out_valid, 0);
        chk("bp_no_queue_in_ready", o_in_ready, 1);

        // Reset on the third SHIFT cycle of e=7
        drive_in(1'b1, 7, 5);
        tick();
        drive_in(1'b0, 0, 0);
        tick();
        tick();
        chk("mid_rst_busy", o_in_ready, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_in_ready", o_in_ready, 1);
        chk("mid_rst_out_valid", o_out_valid, 0);
        chk("mid_rst_result", o_result, 0);
        chk("mid_rst_exact", o_exact, 0);
        chk("mid_rst_ovf", o_ovf, 0);
        rst = 1'b0;
        run_op("post_rst_e1_f0", 1, 0, 2, 1, 0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
